compute_writeback: RTL and testbench

Sink end of the compute datapath: accepts results from the add/sub, shift, reduction and ALU units over a valid/ready handshake, updates the N/Z/V flag register, and buffers results in a 2-entry in-order queue that drains into the register-file write port. It also exports a pending-destination vector so decode can detect read-after-write hazards on results not yet written back.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/wb_fifo2.sv | 64 ++++++
 rtl/compute_writeback.sv | 103 ++++++++++
 tb/tb_compute_writeback.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and constants for the compute writeback stage
package wb_pkg;

   localparam int WB_DEPTH = 2;
   localparam int DW       = 16;

   typedef enum logic [3:0] {
      OP_ADD    = 4'b0000,
      OP_SUB    = 4'b0001,
      OP_XOR    = 4'b0010,
      OP_RED    = 4'b0011,
      OP_SLL    = 4'b0100,
      OP_SRA    = 4'b0101,
      OP_ROR    = 4'b0110,
      OP_PADDSB = 4'b0111
   } opcode_e;

   typedef struct packed {
      logic n;
      logic z;
      logic v;
   } flags_t;

   typedef struct packed {
      logic [3:0]    dst;
      logic [DW-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry in-order result queue; slot 0 is always the head
module wb_fifo2
   import wb_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic            pop_i,
   input  wb_entry_t       din_i,
   output logic [1:0]      count_o,
   output wb_entry_t       head_o,
   output wb_entry_t [1:0] entries_o,
   output logic [1:0]      valid_o
);

   wb_entry_t  slot0_q, slot0_d;
   wb_entry_t  slot1_q, slot1_d;
   logic [1:0] count_q, count_d;
   logic       do_push, do_pop;

   // A full queue never accepts, even when it pops in the same cycle.
   assign do_pop  = pop_i & (count_q != 2'd0);
   assign do_push = push_i & (count_q != 2'd2);

   always_comb begin
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10: begin
            if (count_q == 2'd0) slot0_d = din_i;
            else                 slot1_d = din_i;
            count_d = count_q + 2'd1;
         end
         2'b01: begin
            slot0_d = slot1_q;
            count_d = count_q - 2'd1;
         end
         2'b11: begin
            slot0_d = din_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
         count_q <= count_d;
      end
   end

   assign count_o      = count_q;
   assign head_o       = slot0_q;
   assign entries_o[0] = slot0_q;
   assign entries_o[1] = slot1_q;
   assign valid_o      = {count_q == 2'd2, count_q != 2'd0};

endmodule

// File: rtl/compute_writeback.sv
// rtl/compute_writeback.sv - result sink: flags, dst-0 filter, pending vector, queued writeback; WB_BYPASS_EN enables same-cycle bypass
module compute_writeback
   import wb_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_opcode,
   input  logic [DW-1:0] in_result,
   input  logic          in_ovfl,
   input  logic [3:0]    in_dst,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [3:0]    wb_addr,
   output logic [DW-1:0] wb_data,
   output logic [2:0]    flags,
   output logic [15:0]   pending
);

   flags_t          flags_q, flags_d;
   logic [1:0]      count;
   wb_entry_t       head;
   wb_entry_t [1:0] entries;
   logic [1:0]      ent_valid;
   wb_entry_t       din;
   logic            accept, push, pop;

   assign in_ready = (count < 2'(WB_DEPTH));
   assign accept   = in_valid & in_ready;
   assign pop      = (count != 2'd0) & wb_ready;
   assign din      = '{dst: in_dst, data: in_result};

`ifdef WB_BYPASS_EN
   logic byp;
   assign byp  = (count == 2'd0) & in_valid & (in_dst != 4'd0);
   assign push = accept & (in_dst != 4'd0) & ~(byp & wb_ready);
`else
   assign push = accept & (in_dst != 4'd0);
`endif

   wb_fifo2 u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push_i    (push),
      .pop_i     (pop),
      .din_i     (din),
      .count_o   (count),
      .head_o    (head),
      .entries_o (entries),
      .valid_o   (ent_valid)
   );

   always_comb begin
      flags_d = flags_q;
      if (accept) begin
         case (in_opcode)
            OP_ADD, OP_SUB: begin
               flags_d.z = (in_result == '0);
               flags_d.n = in_result[DW-1];
               flags_d.v = in_ovfl;
            end
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags_d.z = (in_result == '0);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) flags_q <= '0;
      else     flags_q <= flags_d;
   end

   assign flags = flags_q;

   always_comb begin
      pending = 16'h0000;
      for (int i = 0; i < WB_DEPTH; i++) begin
         if (ent_valid[i]) pending = pending | (16'h0001 << entries[i].dst);
      end
   end

   always_comb begin
      wb_valid = 1'b0;
      wb_addr  = 4'd0;
      wb_data  = '0;
      if (count != 2'd0) begin
         wb_valid = 1'b1;
         wb_addr  = head.dst;
         wb_data  = head.data;
      end
`ifdef WB_BYPASS_EN
      else if (byp) begin
         wb_valid = 1'b1;
         wb_addr  = in_dst;
         wb_data  = in_result;
      end
`endif
      // Entries being discarded by reset must not reach the register file.
      if (rst) wb_valid = 1'b0;
   end

endmodule

// File: tb/tb_compute_writeback.sv
// tb/tb_compute_writeback.sv - directed self-checking bench for compute_writeback
module tb_compute_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [15:0] in_result;
   logic        in_ovfl;
   logic [3:0]  in_dst;
   logic        wb_valid;
   logic        wb_ready;
   logic [3:0]  wb_addr;
   logic [15:0] wb_data;
   logic [2:0]  flags;
   logic [15:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   compute_writeback dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opcode (in_opcode),
      .in_result (in_result),
      .in_ovfl   (in_ovfl),
      .in_dst    (in_dst),
      .wb_valid  (wb_valid),
      .wb_ready  (wb_ready),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .flags     (flags),
      .pending   (pending)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] res,
                        input logic ov, input logic [3:0] dst);
      in_valid  = v;
      in_opcode = op;
      in_result = res;
      in_ovfl   = ov;
      in_dst    = dst;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; wb_ready = 1'b0;
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
      tick(); tick();
      rst = 1'b0;
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
      n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", flags); end
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid got %0b exp 0", wb_valid); end
      n_checks++; if ({wb_addr, wb_data} !== 20'h0) begin n_fail++; $display("FAIL reset_wb_port got %h/%h exp 0/0", wb_addr, wb_data); end
      n_checks++; if (pending !== 16'h0) begin n_fail++; $display("FAIL reset_pending got %h exp 0000", pending); end
   endtask

   task automatic test_add_zero();
      wb_ready = 1'b0;
      drive(1'b1, 4'b0000, 16'h0000, 1'b0, 4'd3);
      tick();
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
      n_checks++; if (flags !== 3'b010) begin n_fail++; $display("FAIL add_flags got %b exp 010", flags); end
      n_checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 16'h0000) begin
         n_fail++; $display("FAIL add_wb got v=%0b a=%0d d=%h exp v=1 a=3 d=0000", wb_valid, wb_addr, wb_data); end
      n_checks++; if (pending !== 16'h0008) begin n_fail++; $display("FAIL add_pending got %h exp 0008", pending); end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
      #1;
      n_checks++; if (wb_valid !== 1'b0 || pending !== 16'h0) begin
         n_fail++; $display("FAIL add_drain got v=%0b p=%h exp v=0 p=0000", wb_valid, pending); end
   endtask

   task automatic test_fill_and_refuse();
      wb_ready = 1'b0;
      drive(1'b1, 4'b0001, 16'h8000, 1'b1, 4'd1);
      tick();
      n_checks++; if (flags !== 3'b101) begin n_fail++; $display("FAIL sub_flags got %b exp 101", flags); end
      drive(1'b1, 4'b0010, 16'h0005, 1'b0, 4'd2);
      tick();
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
      n_checks++; if (flags !== 3'b101) begin n_fail++; $display("FAIL xor_flags got %b exp 101", flags); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
      n_checks++; if (pending !== 16'h0006) begin n_fail++; $display("FAIL full_pending got %h exp 0006", pending); end
      n_checks++; if (wb_addr !== 4'd1 || wb_data !== 16'h8000) begin
         n_fail++; $display("FAIL full_head got a=%0d d=%h exp a=1 d=8000", wb_addr, wb_data); end
      // ADD zero would set flags to 010 if it were wrongly accepted.
      drive(1'b1, 4'b0000, 16'h0000, 1'b0, 4'd4);
      tick();
      n_checks++; if (flags !== 3'b101 || pending !== 16'h0006) begin
         n_fail++; $display("FAIL third_push_refused got f=%b p=%h exp f=101 p=0006", flags, pending); end
      n_checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd1 || wb_data !== 16'h8000) begin
         n_fail++; $display("FAIL stall_hold got v=%0b a=%0d d=%h exp v=1 a=1 d=8000", wb_valid, wb_addr, wb_data); end
   endtask

   task automatic test_full_pop_in_valid();
      wb_ready = 1'b1;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_in_ready got %0b exp 0", in_ready); end
      tick();
      n_checks++; if (flags !== 3'b101 || wb_addr !== 4'd2 || wb_data !== 16'h0005 || pending !== 16'h0004) begin
         n_fail++; $display("FAIL full_pop_no_accept got f=%b a=%0d d=%h p=%h exp f=101 a=2 d=0005 p=0004", flags, wb_addr, wb_data, pending); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL after_pop_in_ready got %0b exp 1", in_ready); end
      tick();
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
      n_checks++; if (flags !== 3'b010 || wb_addr !== 4'd4 || wb_data !== 16'h0000 || pending !== 16'h0010) begin
         n_fail++; $display("FAIL push_pop_order got f=%b a=%0d d=%h p=%h exp f=010 a=4 d=0000 p=0010", flags, wb_addr, wb_data, pending); end
      tick();
      n_checks++; if (wb_valid !== 1'b0 || wb_addr !== 4'd0 || wb_data !== 16'h0) begin
         n_fail++; $display("FAIL drained_empty got v=%0b a=%0d d=%h exp v=0 a=0 d=0000", wb_valid, wb_addr, wb_data); end
      wb_ready = 1'b0;
   endtask

   task automatic test_dst_zero();
      wb_ready = 1'b0;
      drive(1'b1, 4'b0001, 16'h8000, 1'b1, 4'd0);
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL dst0_same_cycle got %0b exp 0", wb_valid); end
      tick();
      drive(1'b1, 4'b0011, 16'h0000, 1'b0, 4'd0);
      n_checks++; if (flags !== 3'b101) begin n_fail++; $display("FAIL dst0_sub_flags got %b exp 101", flags); end
      tick();
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
      n_checks++; if (flags !== 3'b101 || wb_valid !== 1'b0 || pending !== 16'h0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL red_dst0 got f=%b v=%0b p=%h r=%0b exp f=101 v=0 p=0000 r=1", flags, wb_valid, pending, in_ready); end
   endtask

   task automatic test_reset_mid();
      wb_ready = 1'b0;
      drive(1'b1, 4'b0001, 16'h8000, 1'b1, 4'd6);
      tick();
      drive(1'b1, 4'b0000, 16'h0002, 1'b0, 4'd7);
      tick();
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
      n_checks++; if (pending !== 16'h00C0 || in_ready !== 1'b0) begin
         n_fail++; $display("FAIL pre_reset got p=%h r=%0b exp p=00c0 r=0", pending, in_ready); end
      rst = 1'b1; wb_ready = 1'b1;
      #1;
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cycle_write got %0b exp 0", wb_valid); end
      tick();
      rst = 1'b0; wb_ready = 1'b0;
      #1;
      n_checks++; if (wb_valid !== 1'b0 || flags !== 3'b000 || pending !== 16'h0 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL post_reset got v=%0b f=%b p=%h r=%0b exp v=0 f=000 p=0000 r=1", wb_valid, flags, pending, in_ready); end
   endtask

   task automatic test_opcode_high();
      wb_ready = 1'b0;
      drive(1'b1, 4'b1010, 16'h0000, 1'b1, 4'd9);
      tick();
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
      n_checks++; if (flags !== 3'b000 || pending !== 16'h0200 || wb_addr !== 4'd9 || wb_valid !== 1'b1) begin
         n_fail++; $display("FAIL op_high got f=%b p=%h a=%0d v=%0b exp f=000 p=0200 a=9 v=1", flags, pending, wb_addr, wb_valid); end
      wb_ready = 1'b1;
      tick();
      wb_ready = 1'b0;
   endtask

   task automatic test_bypass();
      wb_ready = 1'b1;
      drive(1'b1, 4'b0000, 16'h1234, 1'b0, 4'd5);
`ifdef WB_BYPASS_EN
      n_checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd5 || wb_data !== 16'h1234 || pending !== 16'h0) begin
         n_fail++; $display("FAIL bypass_same got v=%0b a=%0d d=%h p=%h exp v=1 a=5 d=1234 p=0000", wb_valid, wb_addr, wb_data, pending); end
`else
      n_checks++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL nobypass_same got %0b exp 0", wb_valid); end
`endif
      tick();
      drive(1'b0, 4'h0, 16'h0, 1'b0, 4'h0);
`ifdef WB_BYPASS_EN
      n_checks++; if (wb_valid !== 1'b0 || pending !== 16'h0) begin
         n_fail++; $display("FAIL bypass_next got v=%0b p=%h exp v=0 p=0000", wb_valid, pending); end
`else
      n_checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd5 || wb_data !== 16'h1234 || pending !== 16'h0020) begin
         n_fail++; $display("FAIL nobypass_next got v=%0b a=%0d d=%h p=%h exp v=1 a=5 d=1234 p=0020", wb_valid, wb_addr, wb_data, pending); end
`endif
      n_checks++; if (flags !== 3'b000) begin n_fail++; $display("FAIL bypass_flags got %b exp 000", flags); end
      tick();
      wb_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_add_zero();
      test_fill_and_refuse();
      test_full_pop_in_valid();
      test_dst_zero();
      test_reset_mid();
      test_opcode_high();
      test_bypass();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
